// File: rtl/neopixel_pkg.sv
// Shared definitions for the neopixel frame writer.
//   - Bit positions of the G, R and B bytes inside the 32-bit driver data word
//   - Hue sector boundaries of the colour wheel
//   - FSM state encoding
//   - pack_grb(): assembles the {8'h00, G, R, B} driver word
package neopixel_pkg;

  localparam int GRB_G_LSB = 16;
  localparam int GRB_R_LSB = 8;
  localparam int GRB_B_LSB = 0;

  localparam logic [7:0] HUE_SECTOR_1 = 8'd85;
  localparam logic [7:0] HUE_SECTOR_2 = 8'd170;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [31:0] pack_grb(input logic [7:0] g,
                                           input logic [7:0] r,
                                           input logic [7:0] b);
    logic [31:0] w;
    w = '0;
    w[GRB_G_LSB +: 8] = g;
    w[GRB_R_LSB +: 8] = r;
    w[GRB_B_LSB +: 8] = b;
    return w;
  endfunction

endpackage

// File: rtl/neopixel_frame_writer_if.sv
// Control write port between the frame writer (master) and the neopixel
// driver (slave).
//   ctrl_clock  forwarded clock
//   ctrl_reset  active-high reset to the driver
//   write_en    write request, held until accepted
//   address     pixel index
//   write_data  {8'h00, G, R, B}
//   read_data   driver read data (reserved)
//   ready       driver accepts a write this cycle
interface neopixel_frame_writer_if;
  logic        ctrl_clock;
  logic        ctrl_reset;
  logic        write_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output ctrl_clock, ctrl_reset, write_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  ctrl_clock, ctrl_reset, write_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/neopixel_hue_wheel.sv
// Combinational colour wheel: 8-bit hue -> 24-bit GRB.
//   hue  in   8   hue angle, 0..255
//   grb  out  24  G [23:16], R [15:8], B [7:0]
// Three linear sectors; arithmetic is 10 bits wide and truncated to 8, so
// hue 255 lands on R=255, B=0 without wrapping.
module neopixel_hue_wheel
  import neopixel_pkg::*;
(
  input  logic [7:0]  hue,
  output logic [23:0] grb
);

  logic [9:0] h10;
  logic [9:0] t;
  logic [7:0] r, g, b;

  always_comb begin
    h10 = {2'b00, hue};
    t   = '0;
    r   = '0;
    g   = '0;
    b   = '0;
    if (hue < HUE_SECTOR_1) begin
      t = 10'd3 * h10;
      r = 8'(10'd255 - t);
      g = t[7:0];
    end else if (hue < HUE_SECTOR_2) begin
      t = 10'd3 * (h10 - {2'b00, HUE_SECTOR_1});
      g = 8'(10'd255 - t);
      b = t[7:0];
    end else begin
      t = 10'd3 * (h10 - {2'b00, HUE_SECTOR_2});
      r = t[7:0];
      b = 8'(10'd255 - t);
    end
  end

  always_comb begin
    grb = '0;
    grb[GRB_G_LSB +: 8] = g;
    grb[GRB_R_LSB +: 8] = r;
    grb[GRB_B_LSB +: 8] = b;
  end

endmodule

// File: rtl/neopixel_frame_writer.sv
// Autonomous colour-wheel pattern source for the neopixel driver. Every
// C_RATE clocks (when enabled) it writes one GRB word per pixel to addresses
// 0..C_PIXELS-1, then advances the base hue by one.
//   clock        in   single clock, forwarded as ctrl.ctrl_clock
//   reset_n      in   asynchronous active-low reset
//   enable       in   1 = frame ticks start frames
//   brightness   in   [7:0] channel scale (only with NEOPIXEL_BRIGHTNESS_EN)
//   ctrl         master modport of neopixel_frame_writer_if
//   frame_count  out  [15:0] completed frames, wrapping
//   overrun      out  sticky: tick arrived while a frame was in progress
// Optional feature macro: NEOPIXEL_BRIGHTNESS_EN adds the brightness input
// and scales each channel by (brightness+1)/256 at the LOAD stage.
module neopixel_frame_writer
  import neopixel_pkg::*;
#(
  parameter int C_PIXELS   = 12,
  parameter int C_RATE     = 33000000,
  parameter int C_HUE_STEP = 21
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
`ifdef NEOPIXEL_BRIGHTNESS_EN
  input  logic [7:0]              brightness,
`endif
  neopixel_frame_writer_if.master ctrl,
  output logic [15:0]             frame_count,
  output logic                    overrun
);

  localparam int               CNT_W     = $clog2(C_RATE);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(C_RATE - 1);
  localparam logic [7:0]       PIX_LAST  = 8'(C_PIXELS - 1);
  localparam logic [7:0]       HUE_STEP  = 8'(C_HUE_STEP);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] rate_cnt;
  logic             tick;
  logic             transfer;
  logic [7:0]       idx;
  logic [7:0]       pix_hue;
  logic [7:0]       base_hue;
  logic [23:0]      wheel_grb;
  logic [7:0]       g_c, r_c, b_c;
  logic [31:0]      address_q;
  logic [31:0]      data_q;
  logic             unused_read;

  assign unused_read = ^ctrl.read_data;

  // Free-running frame rate counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  rate_cnt <= '0;
    else if (tick) rate_cnt <= '0;
    else           rate_cnt <= rate_cnt + CNT_W'(1);
  end

  assign tick     = (rate_cnt == RATE_LAST);
  assign transfer = (state == ST_WRITE) && ctrl.ready;

  // Colour for the current pixel; pix_hue tracks base_hue + idx*C_HUE_STEP
  // incrementally so no multiplier is needed.
  neopixel_hue_wheel u_wheel (
    .hue (pix_hue),
    .grb (wheel_grb)
  );

`ifdef NEOPIXEL_BRIGHTNESS_EN
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] lvl);
    logic [15:0] p;
    p = 16'(c) * (16'(lvl) + 16'd1);
    return p[15:8];
  endfunction

  assign g_c = scale(wheel_grb[GRB_G_LSB +: 8], brightness);
  assign r_c = scale(wheel_grb[GRB_R_LSB +: 8], brightness);
  assign b_c = scale(wheel_grb[GRB_B_LSB +: 8], brightness);
`else
  assign g_c = wheel_grb[GRB_G_LSB +: 8];
  assign r_c = wheel_grb[GRB_R_LSB +: 8];
  assign b_c = wheel_grb[GRB_B_LSB +: 8];
`endif

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (tick && enable) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_WRITE;
      ST_WRITE: if (transfer) state_nxt = (idx == PIX_LAST) ? ST_DONE : ST_LOAD;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: the request is live for exactly the WRITE state, so a
  // reset drops it immediately.
  always_comb begin
    ctrl.write_en = (state == ST_WRITE);
  end

  // Frame datapath and status
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx         <= '0;
      pix_hue     <= '0;
      base_hue    <= '0;
      address_q   <= '0;
      data_q      <= '0;
      frame_count <= '0;
      overrun     <= 1'b0;
    end else begin
      if (tick && (state != ST_IDLE)) overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (tick && enable) begin
            idx     <= '0;
            pix_hue <= base_hue;
          end
        end
        ST_LOAD: begin
          address_q <= {24'h0, idx};
          data_q    <= pack_grb(g_c, r_c, b_c);
        end
        ST_WRITE: begin
          if (transfer && (idx != PIX_LAST)) begin
            idx     <= idx + 8'd1;
            pix_hue <= pix_hue + HUE_STEP;
          end
        end
        ST_DONE: begin
          base_hue    <= base_hue + 8'd1;
          frame_count <= frame_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign ctrl.ctrl_clock = clock;
  assign ctrl.ctrl_reset = ~reset_n;
  assign ctrl.address    = address_q;
  assign ctrl.write_data = data_q;

endmodule

// File: tb/tb_neopixel_frame_writer.sv
// Directed bench for neopixel_frame_writer with C_PIXELS=4, C_RATE=100,
// C_HUE_STEP=21. A driver model logs every accepted write and watches that a
// pending request holds still while ready is low.
module tb_neopixel_frame_writer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b1;
  logic ready_q = 1'b1;
  int   ready_mode = 1;   // 0 = low, 1 = high, 2 = toggle every 3 clocks
  int   tog_cnt = 0;
  logic [15:0] frame_count;
  logic        overrun;

  int n_chk = 0;
  int n_pass = 0;
  int stab_err = 0;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic        hold_pend = 1'b0;
  logic [31:0] hold_addr = '0;
  logic [31:0] hold_data = '0;

  neopixel_frame_writer_if bus ();

  assign bus.ready     = ready_q;
  assign bus.read_data = '0;

  neopixel_frame_writer #(
    .C_PIXELS   (4),
    .C_RATE     (100),
    .C_HUE_STEP (21)
  ) dut (
    .clock       (clk),
    .reset_n     (reset_n),
    .enable      (enable),
`ifdef NEOPIXEL_BRIGHTNESS_EN
    .brightness  (8'hFF),
`endif
    .ctrl        (bus),
    .frame_count (frame_count),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Driver model: ready pattern, changed just after the rising edge
  always begin
    @(posedge clk);
    #1;
    if (ready_mode == 0) ready_q = 1'b0;
    else if (ready_mode == 1) ready_q = 1'b1;
    else begin
      tog_cnt++;
      if (tog_cnt >= 3) begin
        ready_q = ~ready_q;
        tog_cnt = 0;
      end
    end
  end

  // Driver model: accept writes, check held requests stay stable
  always @(negedge clk) begin
    if (!reset_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend && (!bus.write_en || bus.address != hold_addr ||
                        bus.write_data != hold_data))
        stab_err++;
      hold_pend = bus.write_en && !bus.ready;
      hold_addr = bus.address;
      hold_data = bus.write_data;
      if (bus.write_en && bus.ready) begin
        log_addr.push_back(bus.address);
        log_data.push_back(bus.write_data);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic wait_frames(input string tag, input int target, input int budget);
    int i;
    i = 0;
    while (frame_count != 16'(target) && i < budget) begin
      @(posedge clk);
      #1;
      i++;
    end
    check(tag, 32'(frame_count), 32'(target));
  endtask

  task automatic check_frame(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] d3);
    logic [31:0] exp_d[4];
    exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2; exp_d[3] = d3;
    check({tag, "_nwrites"}, 32'(log_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < log_addr.size()) begin
        check({tag, "_addr"}, log_addr[i], 32'(i));
        check({tag, "_data"}, log_data[i], exp_d[i]);
      end
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  initial begin
    // Test 1: reset values and first frame
    repeat (3) @(posedge clk);
    #1;
    check("rst_write_en", 32'(bus.write_en), 32'd0);
    check("rst_address", bus.address, 32'h0);
    check("rst_data", bus.write_data, 32'h0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_ctrl_reset", 32'(bus.ctrl_reset), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("t1_no_we_early", 32'(bus.write_en), 32'd0);
    check("t1_ctrl_reset", 32'(bus.ctrl_reset), 32'd0);
    @(posedge clk);
    #1;
    check("t1_first_we", 32'(bus.write_en), 32'd1);
    check("t1_first_addr", bus.address, 32'h0);
    check("t1_first_data", bus.write_data, 32'h0000FF00);
    wait_frames("t1_frame_count", 1, 50);
    check_frame("t1", 32'h0000FF00, 32'h003FC000, 32'h007E8100, 32'h00BD4200);

    // Test 2: ready toggling, base hue 1
    clear_log();
    ready_mode = 2;
    wait_frames("t2_frame_count", 2, 300);
    check_frame("t2", 32'h0003FC00, 32'h0042BD00, 32'h00817E00, 32'h00C03F00);
    check("t2_stable", 32'(stab_err), 32'd0);

    // Test 3: ready low across two ticks, base hue 2
    clear_log();
    ready_mode = 0;
    repeat (250) @(posedge clk);
    #1;
    check("t3_overrun", 32'(overrun), 32'd1);
    check("t3_stall_we", 32'(bus.write_en), 32'd1);
    check("t3_stall_addr", bus.address, 32'h0);
    check("t3_stall_data", bus.write_data, 32'h0006F900);
    check("t3_no_writes", 32'(log_addr.size()), 32'd0);
    ready_mode = 1;
    wait_frames("t3_frame_count", 3, 100);
    check_frame("t3", 32'h0006F900, 32'h0045BA00, 32'h00847B00, 32'h00C33C00);
    check("t3_overrun_sticky", 32'(overrun), 32'd1);
    check("t3_stable", 32'(stab_err), 32'd0);

    // Test 6: asynchronous reset after the second write of a frame
    clear_log();
    begin
      int i;
      i = 0;
      while (log_addr.size() < 2 && i < 200) begin
        @(posedge clk);
        #1;
        i++;
      end
      check("t6_two_writes", 32'(log_addr.size()), 32'd2);
    end
    @(posedge clk);
    #2;
    check("t6_we_before", 32'(bus.write_en), 32'd1);
    check("t6_addr_before", bus.address, 32'h2);
    reset_n = 1'b0;
    #1;
    check("t6_we_async", 32'(bus.write_en), 32'd0);
    check("t6_addr_async", bus.address, 32'h0);
    check("t6_data_async", bus.write_data, 32'h0);
    check("t6_fc_async", 32'(frame_count), 32'd0);
    check("t6_overrun_async", 32'(overrun), 32'd0);
    enable = 1'b0;
    repeat (3) @(posedge clk);
    clear_log();
    @(negedge clk);
    reset_n = 1'b1;

    // Test 4: disabled for three ticks, then base hue still 0
    repeat (350) @(posedge clk);
    #1;
    check("t4_no_writes", 32'(log_addr.size()), 32'd0);
    check("t4_fc_idle", 32'(frame_count), 32'd0);
    check("t4_we_idle", 32'(bus.write_en), 32'd0);
    enable = 1'b1;
    wait_frames("t4_frame_count", 1, 150);
    check_frame("t4", 32'h0000FF00, 32'h003FC000, 32'h007E8100, 32'h00BD4200);

    // Test 5: 256 frames, base hues 1..255 then wrap to 0
    clear_log();
    wait_frames("t5_frame_count_256", 256, 26000);
    if (log_data.size() >= 1020) begin
      check("t5_h84", log_data[332], 32'h00FC0300);
      check("t5_h85", log_data[336], 32'h00FF0000);
      check("t5_h100", log_data[396], 32'h00D2002D);
      check("t5_h170", log_data[676], 32'h000000FF);
      check("t5_h200", log_data[796], 32'h00005AA5);
      check("t5_h255", log_data[1016], 32'h0000FF00);
      check("t5_h20", log_data[1017], 32'h003CC300);
    end else begin
      check("t5_log_size", 32'(log_data.size()), 32'd1020);
    end
    wait_frames("t5_frame_count_257", 257, 200);
    check("t5_nwrites", 32'(log_data.size()), 32'd1024);
    if (log_data.size() >= 1024) begin
      check("t5_wrap_addr", log_addr[1020], 32'h0);
      check("t5_wrap_data", log_data[1020], 32'h0000FF00);
    end
    check("t5_overrun", 32'(overrun), 32'd0);
    check("t5_stable", 32'(stab_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
